instr_fetch: RTL and testbench

Fetch stage of the reduced RISC-V core. It owns the program counter and issues word reads to instruction memory over a ready/valid request and response handshake. Returned words go into a small prefetch FIFO that presents `instr` and its PC to the control/decode stage. It also applies the taken-branch redirect that the control stage signals on `pcsrc`.

---
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, keeps at most one word read outstanding and buffers
// responses in a prefetch FIFO. Define INSTR_FETCH_PERF_EN to add stall/redirect counters.
module instr_fetch #(
   parameter int                    INSTRUCTION_WIDTH = 32,
   parameter int                    ADDR_WIDTH        = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC          = '0,
   parameter int                    DEPTH             = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic                         imem_req,
   output logic [ADDR_WIDTH-1:0]        imem_addr,
   input  logic                         imem_ready,
   input  logic                         imem_rvalid,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_rdata,
   output logic                         instr_valid,
   output logic [INSTRUCTION_WIDTH-1:0] instr,
   output logic [ADDR_WIDTH-1:0]        instr_pc,
`ifdef INSTR_FETCH_PERF_EN
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  redirect_cnt,
`endif
   input  logic                         instr_ready,
   input  logic                         pcsrc,
   input  logic [ADDR_WIDTH-1:0]        immop
);

   localparam int               PTR_W   = $clog2(DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;

   state_e                       state_q, state_d;
   logic [ADDR_WIDTH-1:0]        fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0]        req_pc_q, req_pc_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic [PTR_W-1:0]             rd_ptr_q, wr_ptr_q;
   logic [ADDR_WIDTH-1:0]        pc_mem_q    [DEPTH];
   logic [INSTRUCTION_WIDTH-1:0] instr_mem_q [DEPTH];

   logic                         inflight, pop, push, redirect, handshake;
   logic [CNT_W-1:0]             occupancy;

   // The read in flight is counted against free space, so every response has a slot.
   always_comb begin
      inflight  = (state_q == WAIT);
      occupancy = count_q + {{(CNT_W-1){1'b0}}, inflight};
      pop       = instr_valid && instr_ready;
      redirect  = pop && pcsrc;
      push      = inflight && imem_rvalid && !redirect;
      imem_req  = rst_n && !redirect
                  && ((state_q == IDLE) || (inflight && imem_rvalid))
                  && (occupancy < DEPTH_C);
      handshake = imem_req && imem_ready;
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      req_pc_d   = req_pc_q;
      count_d    = count_q;
      unique case (state_q)
         IDLE:    if (handshake) state_d = WAIT;
         WAIT: begin
            if (imem_rvalid)   state_d = handshake ? WAIT : IDLE;
            else if (redirect) state_d = DROP;
         end
         DROP:    if (imem_rvalid) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (handshake) begin
         fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
         req_pc_d   = fetch_pc_q;
      end
      if (redirect) begin
         fetch_pc_d = (instr_pc + immop) & {{(ADDR_WIDTH-2){1'b1}}, 2'b00};
         count_d    = '0;
      end else if (push && !pop) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         req_pc_q   <= RESET_PC;
         count_q    <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_pc_q   <= req_pc_d;
         count_q    <= count_d;
         if (redirect) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]    <= req_pc_q;
         instr_mem_q[wr_ptr_q] <= imem_rdata;
      end
   end

   assign imem_addr   = fetch_pc_q;
   assign instr_valid = (count_q != '0);
   assign instr       = instr_valid ? instr_mem_q[rd_ptr_q] : '0;
   assign instr_pc    = instr_valid ? pc_mem_q[rd_ptr_q]    : '0;

`ifdef INSTR_FETCH_PERF_EN
   logic [31:0] stall_cnt_q, redirect_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q    <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (instr_valid && !instr_ready) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (redirect)                    redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
   end

   assign stall_cnt    = stall_cnt_q;
   assign redirect_cnt = redirect_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: a latency-programmable memory model feeds a scoreboard
// of {pc, word} pairs that is checked on every pop; scenario tasks add timing checks.
module tb_instr_fetch;

   logic        clk;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        pcsrc;
   logic [31:0] immop;

   int          checks;
   int          failures;
   int          memK;
   int          pend;
   logic [31:0] pendAddr;
   logic [63:0] expQ [$];

   instr_fetch #(
      .INSTRUCTION_WIDTH(32),
      .ADDR_WIDTH       (32),
      .RESET_PC         (32'h0000_0100),
      .DEPTH            (4)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ready (imem_ready),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .instr_valid(instr_valid),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_ready(instr_ready),
      .pcsrc      (pcsrc),
      .immop      (immop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory contents are a fixed function of the address.
   function automatic logic [31:0] memData(input logic [31:0] a);
      return (a * 32'd3) ^ 32'h5A5A_1234;
   endfunction

   task automatic applyReset(input int k);
      @(negedge clk);
      #2;
      memK        = k;
      imem_ready  = 1'b1;
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      immop       = 32'h0;
      rst_n       = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic sampleWindow();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      memK        = 1;
      imem_ready  = 1'b1;
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      immop       = 32'h0;
      rst_n       = 1'b1;
      #1;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      sampleWindow();
      checks++;
      if (imem_req !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got %b expected 0", imem_req); end
      checks++;
      if (instr_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got %b expected 0", instr_valid); end
      checks++;
      if (instr !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got %h expected 0", instr); end
      checks++;
      if (instr_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got %h expected 0", instr_pc); end
      nextCycle();
      rst_n = 1'b1;
      #1;
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100)
         begin failures++; $display("[TB] FAIL first_req got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
   endtask

   task automatic test_stream();
      logic [31:0] expPc;
      applyReset(1);
      instr_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sampleWindow();
         expPc = 32'h100 + 32'(4 * i);
         checks++;
         if (imem_req !== 1'b1 || imem_addr !== expPc)
            begin failures++; $display("[TB] FAIL stream_req i=%0d got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, expPc); end
         checks++;
         if (instr_valid !== (i >= 2))
            begin failures++; $display("[TB] FAIL stream_valid i=%0d got %b expected %b", i, instr_valid, (i >= 2)); end
         if (i >= 2) begin
            expPc = 32'h100 + 32'(4 * (i - 2));
            checks++;
            if (instr_pc !== expPc || instr !== memData(expPc))
               begin failures++; $display("[TB] FAIL stream_head i=%0d got pc=%h instr=%h expected pc=%h instr=%h", i, instr_pc, instr, expPc, memData(expPc)); end
         end
         nextCycle();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] expPc;
      applyReset(1);
      for (int i = 0; i < 10; i++) begin
         sampleWindow();
         checks++;
         if (imem_req !== (i < 4))
            begin failures++; $display("[TB] FAIL bp_req i=%0d got %b expected %b", i, imem_req, (i < 4)); end
         if (i >= 2) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
               begin failures++; $display("[TB] FAIL bp_head i=%0d got valid=%b pc=%h expected valid=1 pc=00000100", i, instr_valid, instr_pc); end
         end
         nextCycle();
      end
      instr_ready = 1'b1;
      for (int j = 0; j < 6; j++) begin
         sampleWindow();
         expPc = 32'h100 + 32'(4 * j);
         checks++;
         if (instr_valid !== 1'b1 || instr_pc !== expPc)
            begin failures++; $display("[TB] FAIL bp_drain j=%0d got valid=%b pc=%h expected valid=1 pc=%h", j, instr_valid, instr_pc, expPc); end
         nextCycle();
      end
   endtask

   task automatic test_redirect_idle();
      applyReset(1);
      repeat (10) nextCycle();
      imem_ready  = 1'b0;
      instr_ready = 1'b1;
      nextCycle();
      nextCycle();
      pcsrc = 1'b1;
      immop = 32'hFFFF_FFF8;
      sampleWindow();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h108 || imem_req !== 1'b0)
         begin failures++; $display("[TB] FAIL redir_idle_cycle got valid=%b pc=%h req=%b expected valid=1 pc=00000108 req=0", instr_valid, instr_pc, imem_req); end
      nextCycle();
      pcsrc      = 1'b0;
      immop      = 32'h0;
      imem_ready = 1'b1;
      sampleWindow();
      checks++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100)
         begin failures++; $display("[TB] FAIL redir_idle_target got valid=%b req=%b addr=%h expected valid=0 req=1 addr=00000100", instr_valid, imem_req, imem_addr); end
      nextCycle();
      nextCycle();
      sampleWindow();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
         begin failures++; $display("[TB] FAIL redir_idle_refill got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
   endtask

   task automatic test_redirect_wait();
      applyReset(3);
      instr_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         pcsrc = (i == 4);
         immop = (i == 4) ? 32'h22 : 32'h0;
         sampleWindow();
         if (i == 4) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || imem_req !== 1'b0)
               begin failures++; $display("[TB] FAIL redir_wait_cycle got valid=%b pc=%h req=%b expected valid=1 pc=00000100 req=0", instr_valid, instr_pc, imem_req); end
         end
         if (i == 5 || i == 6) begin
            checks++;
            if (imem_req !== 1'b0)
               begin failures++; $display("[TB] FAIL redir_wait_drop i=%0d got req=%b expected 0", i, imem_req); end
         end
         if (i == 7) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h120)
               begin failures++; $display("[TB] FAIL redir_wait_target got req=%b addr=%h expected req=1 addr=00000120", imem_req, imem_addr); end
         end
         if (i >= 5 && i <= 10) begin
            checks++;
            if (instr_valid !== 1'b0)
               begin failures++; $display("[TB] FAIL redir_wait_stale i=%0d got valid=%b expected 0", i, instr_valid); end
         end
         if (i == 11) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h120)
               begin failures++; $display("[TB] FAIL redir_wait_refill got valid=%b pc=%h expected valid=1 pc=00000120", instr_valid, instr_pc); end
         end
         nextCycle();
      end
      pcsrc = 1'b0;
      immop = 32'h0;
   endtask

   task automatic test_redirect_rvalid();
      applyReset(3);
      for (int i = 0; i < 12; i++) begin
         instr_ready = !(i == 4 || i == 5);
         pcsrc       = (i == 6);
         immop       = (i == 6) ? 32'h40 : 32'h0;
         sampleWindow();
         if (i == 6) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || imem_req !== 1'b0)
               begin failures++; $display("[TB] FAIL redir_rv_cycle got valid=%b pc=%h req=%b expected valid=1 pc=00000100 req=0", instr_valid, instr_pc, imem_req); end
         end
         if (i == 7) begin
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h140)
               begin failures++; $display("[TB] FAIL redir_rv_target got req=%b addr=%h expected req=1 addr=00000140", imem_req, imem_addr); end
         end
         if (i >= 7 && i <= 10) begin
            checks++;
            if (instr_valid !== 1'b0)
               begin failures++; $display("[TB] FAIL redir_rv_stale i=%0d got valid=%b expected 0", i, instr_valid); end
         end
         if (i == 11) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_pc !== 32'h140)
               begin failures++; $display("[TB] FAIL redir_rv_refill got valid=%b pc=%h expected valid=1 pc=00000140", instr_valid, instr_pc); end
         end
         nextCycle();
      end
      pcsrc = 1'b0;
      immop = 32'h0;
   endtask

   task automatic test_reset_mid();
      applyReset(1);
      repeat (3) nextCycle();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100)
         begin failures++; $display("[TB] FAIL midrst_before got valid=%b pc=%h expected valid=1 pc=00000100", instr_valid, instr_pc); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0)
         begin failures++; $display("[TB] FAIL midrst_async got req=%b valid=%b instr=%h pc=%h expected all zero", imem_req, instr_valid, instr, instr_pc); end
      nextCycle();
      rst_n       = 1'b1;
      instr_ready = 1'b1;
      sampleWindow();
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h100)
         begin failures++; $display("[TB] FAIL midrst_restart got req=%b addr=%h expected req=1 addr=00000100", imem_req, imem_addr); end
      nextCycle();
      nextCycle();
      sampleWindow();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== memData(32'h100))
         begin failures++; $display("[TB] FAIL midrst_refill got valid=%b pc=%h instr=%h expected valid=1 pc=00000100 instr=%h", instr_valid, instr_pc, instr, memData(32'h100)); end
      nextCycle();
   endtask

   initial begin
      checks      = 0;
      failures    = 0;
      memK        = 1;
      pend        = 0;
      pendAddr    = 32'h0;
      rst_n       = 1'b1;
      imem_ready  = 1'b1;
      imem_rvalid = 1'b0;
      imem_rdata  = 32'h0;
      instr_ready = 1'b0;
      pcsrc       = 1'b0;
      immop       = 32'h0;

      // Memory model and scoreboard: responses are driven just after each rising
      // edge, handshakes and pops are observed mid-cycle.
      fork
         forever begin
            @(posedge clk);
            #1;
            imem_rvalid = 1'b0;
            if (!rst_n) begin
               pend = 0;
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  imem_rvalid = 1'b1;
                  imem_rdata  = memData(pendAddr);
               end
            end
            @(negedge clk);
            if (!rst_n) begin
               expQ.delete();
               pend        = 0;
               imem_rvalid = 1'b0;
            end else begin
               if (instr_valid && instr_ready) begin
                  checks++;
                  if (expQ.size() == 0) begin
                     failures++;
                     $display("[TB] FAIL sb_pop got pc=%h instr=%h expected no entry", instr_pc, instr);
                  end else if ({instr_pc, instr} !== expQ[0]) begin
                     failures++;
                     $display("[TB] FAIL sb_pop got pc=%h instr=%h expected pc=%h instr=%h", instr_pc, instr, expQ[0][63:32], expQ[0][31:0]);
                     void'(expQ.pop_front());
                  end else begin
                     void'(expQ.pop_front());
                  end
                  if (pcsrc) expQ.delete();
               end
               if (imem_req && imem_ready) begin
                  checks++;
                  if (pend != 0 || imem_addr[1:0] !== 2'b00) begin
                     failures++;
                     $display("[TB] FAIL req_protocol got addr=%h outstanding=%0d expected aligned addr and none outstanding", imem_addr, pend);
                  end
                  expQ.push_back({imem_addr, memData(imem_addr)});
                  pend     = memK;
                  pendAddr = imem_addr;
               end
            end
         end
      join_none

      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_idle();
      test_redirect_wait();
      test_redirect_rvalid();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
